cache_tag_query_assoc: RTL and testbench
========================================

# cache_tag_query_assoc

Parametrised N-way set-associative tag lookup for the L1 instruction cache, replacing the direct-mapped tag query stage. It sits between the fetch address generator and the cache data read stage. Each accepted lookup produces a registered hit/miss result, with the matching way, two cycles later. It also accepts line fills from the miss handler, selects the way to replace, and clears every valid bit on an invalidate-all.

## Interface
- offsetSize, 5, byte-offset bits within a line
- indexSize, 6, set-index bits; numSets = 2**indexSize
- tagSize, 64-(offsetSize+indexSize), tag bits
- numWays, 4, associativity; power of two, 1..8
- wayBits, max(1, clog2(numWays)), way-number width
- clock_i  in  1  single clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- fetchEnable_i  in  1  lookup request
- tag_i / index_i / offset_i  in  tagSize / indexSize / offsetSize  lookup address fields
- stall_i  in  1  downstream stall; freezes the pipeline
- flushPipeline_i  in  1  kill all in-flight lookups
- updateEnable_i  in  1  fill request
- newTag_i / newIndex_i  in  tagSize / indexSize  fill tag and set
- invalidateAll_i  in  1  clear all valid bits
- ready_o  out  1  lookup accepted this cycle when high with fetchEnable_i
- fillWay_o  out  wayBits  combinational way the current fill writes
- enable_o  out  1  result valid
- hit_o  out  1  tag matched a valid way
- hitWay_o  out  wayBits  matching way; 0 on miss
- tag_o / index_o / offset_o  out  tagSize / indexSize / offsetSize  address of the result

## Operation
- Storage is held in flops: per set, numWays entries of {valid, tag[tagSize]}, plus a wayBits-wide round-robin pointer.
- ready_o = !stall_i && !updateEnable_i && !invalidateAll_i. Fills and invalidates take priority over lookups.
- Accept: when fetchEnable_i && ready_o, stage 1 (S1) captures the tag, index, offset and valid=1. When not stalled and nothing is accepted, S1 valid is set to 0.
- Compare, in S1 to S2:
  - Every way of the S1 set is compared against the S1 tag, using valid && equal.
  - The array contents used include a fill committing in the same cycle to the same set (write forwarding). A same-cycle invalidateAll_i forces a miss.
  - The lowest matching way wins.
  - S2 registers hit, way and address; enable_o = S1 valid.
- Fill, on updateEnable_i (invalidateAll_i low):
  - If newTag_i is already valid in the set, fillWay_o is that way and the pointer is unchanged.
  - Otherwise, if an invalid way exists, fillWay_o is the lowest-numbered invalid way and the pointer is unchanged.
  - Otherwise fillWay_o is the pointer, and the pointer increments modulo numWays, wrapping from numWays-1 to 0.
  - The chosen entry is written with valid=1 and tag=newTag_i.
- invalidateAll_i: all valid bits and pointers clear on the next edge. A fill in the same cycle is dropped. Tag contents are don't-care.
- stall_i: S1 and S2 hold and outputs hold. Fills and invalidates still execute. A held S1 lookup compares on the edge it advances, so its result reflects those updates.
- flushPipeline_i: S1 valid and enable_o clear on the next edge. It overrides stall_i. Array state is untouched.
- fetchEnable_i && updateEnable_i together: the fill executes, the lookup is not accepted (ready_o=0), and the requester retries.

## Timing
- Reset values: enable_o=0, hit_o=0, hitWay_o=0, tag_o/index_o/offset_o=0, all valid bits 0, all pointers 0, S1 valid 0.
- Reset applies immediately on assertion regardless of clock, and aborts any operation in flight.
- Lookup latency is 2 edges. A request accepted at edge N gives enable_o high from edge N+1 through edge N+2; with no stall, it is high in the cycle after edge N+1.
- Throughput is one lookup per cycle when not stalled.
- A fill becomes visible to a lookup sitting in S1 in the same cycle (forwarded).
- fillWay_o is combinational from updateEnable_i, newIndex_i and newTag_i, and is valid in the same cycle.
- The fill write occurs at the edge ending the update cycle.

## Test plan
- After reset, a lookup of tag 0x1, index 3 -> enable_o high two edges later, hit_o=0, hitWay_o=0.
- Fill index 3 with tags 0xA, 0xB, 0xC, 0xD -> fillWay_o = 0, 1, 2, 3. Then a lookup of tag 0xC at index 3 -> hit_o=1, hitWay_o=2.
- With set 3 full, a fifth fill of 0xE -> fillWay_o=0, pointer=1. A sixth fill of 0xF -> fillWay_o=1. A lookup of 0xA now misses. Refilling 0xE -> fillWay_o=0 with the pointer unchanged.
- Lookup of tag 0x7, index 5 accepted at edge N, and a fill of 0x7 into index 5 in the cycle after N -> hit_o=1 (forwarding). fetchEnable_i and updateEnable_i together -> ready_o=0 and no result is issued.
- Three back-to-back lookups with stall_i held for 3 cycles mid-stream -> outputs frozen during the stall and all three results delivered in order. flushPipeline_i asserted during the stall -> enable_o=0 on the next edge.
- invalidateAll_i, or reset_i pulsed asynchronously between edges -> all subsequent lookups miss, and the next fill to any set gives fillWay_o=0.

Source files
------------

// File: rtl/cache_tag_query_assoc.sv
// N-way set-associative tag lookup for the L1 instruction cache.
// Two-stage lookup pipeline with fill-way selection and invalidate-all.
module cache_tag_query_assoc #(
    parameter int offsetSize = 5,
    parameter int indexSize  = 6,
    parameter int tagSize    = 64 - (offsetSize + indexSize),
    parameter int numWays    = 4,
    parameter int wayBits    = (numWays > 1) ? $clog2(numWays) : 1
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  fetchEnable_i,
    input  logic [tagSize-1:0]    tag_i,
    input  logic [indexSize-1:0]  index_i,
    input  logic [offsetSize-1:0] offset_i,
    input  logic                  stall_i,
    input  logic                  flushPipeline_i,
    input  logic                  updateEnable_i,
    input  logic [tagSize-1:0]    newTag_i,
    input  logic [indexSize-1:0]  newIndex_i,
    input  logic                  invalidateAll_i,
    output logic                  ready_o,
    output logic [wayBits-1:0]    fillWay_o,
    output logic                  enable_o,
    output logic                  hit_o,
    output logic [wayBits-1:0]    hitWay_o,
    output logic [tagSize-1:0]    tag_o,
    output logic [indexSize-1:0]  index_o,
    output logic [offsetSize-1:0] offset_o
);

    localparam int numSets = 2 ** indexSize;

    logic [numWays-1:0] valid_q [numSets];
    logic [tagSize-1:0] tag_q   [numSets][numWays];
    logic [wayBits-1:0] ptr_q   [numSets];

    logic                  s1_valid;
    logic [tagSize-1:0]    s1_tag;
    logic [indexSize-1:0]  s1_index;
    logic [offsetSize-1:0] s1_offset;

    logic                  do_fill;
    logic                  accept;
    logic [numWays-1:0]    fill_match;
    logic [numWays-1:0]    fill_free;
    logic [wayBits-1:0]    match_way;
    logic [wayBits-1:0]    free_way;
    logic [wayBits-1:0]    fill_way;
    logic                  fill_evict;
    logic [wayBits-1:0]    ptr_next;

    logic [numWays-1:0]    cmp_match;
    logic                  cmp_hit;
    logic [wayBits-1:0]    cmp_way;

    assign ready_o   = !stall_i && !updateEnable_i && !invalidateAll_i;
    assign accept    = fetchEnable_i && ready_o;
    assign do_fill   = updateEnable_i && !invalidateAll_i;
    assign fillWay_o = fill_way;

    // Fill way: existing copy first, then lowest free way, then round-robin.
    always_comb begin
        fill_match = '0;
        fill_free  = '0;
        match_way  = '0;
        free_way   = '0;
        fill_way   = '0;
        fill_evict = 1'b0;
        ptr_next   = '0;
        for (int w = 0; w < numWays; w++) begin
            fill_match[w] = valid_q[newIndex_i][w] &&
                            (tag_q[newIndex_i][w] == newTag_i);
            fill_free[w]  = !valid_q[newIndex_i][w];
        end
        for (int w = numWays - 1; w >= 0; w--) begin
            if (fill_match[w]) match_way = wayBits'(w);
            if (fill_free[w])  free_way  = wayBits'(w);
        end
        if (|fill_match) begin
            fill_way = match_way;
        end else if (|fill_free) begin
            fill_way = free_way;
        end else begin
            fill_way   = ptr_q[newIndex_i];
            fill_evict = 1'b1;
        end
        if (ptr_q[newIndex_i] == wayBits'(numWays - 1))
            ptr_next = '0;
        else
            ptr_next = ptr_q[newIndex_i] + wayBits'(1);
    end

    // Compare sees a same-cycle fill to the S1 set as already written.
    always_comb begin
        cmp_match = '0;
        cmp_way   = '0;
        for (int w = 0; w < numWays; w++) begin
            if (do_fill && (newIndex_i == s1_index) &&
                (fill_way == wayBits'(w)))
                cmp_match[w] = (newTag_i == s1_tag);
            else
                cmp_match[w] = valid_q[s1_index][w] &&
                               (tag_q[s1_index][w] == s1_tag);
        end
        for (int w = numWays - 1; w >= 0; w--) begin
            if (cmp_match[w]) cmp_way = wayBits'(w);
        end
        cmp_hit = (|cmp_match) && !invalidateAll_i;
        if (!cmp_hit) cmp_way = '0;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int s = 0; s < numSets; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else if (invalidateAll_i) begin
            for (int s = 0; s < numSets; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else if (do_fill) begin
            valid_q[newIndex_i][fill_way] <= 1'b1;
            if (fill_evict) ptr_q[newIndex_i] <= ptr_next;
        end
    end

    // Tag contents carry no reset; valid bits gate every use.
    always_ff @(posedge clock_i) begin
        if (do_fill) tag_q[newIndex_i][fill_way] <= newTag_i;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            s1_valid  <= 1'b0;
            s1_tag    <= '0;
            s1_index  <= '0;
            s1_offset <= '0;
        end else if (flushPipeline_i) begin
            s1_valid <= 1'b0;
        end else if (!stall_i) begin
            s1_valid <= accept;
            if (accept) begin
                s1_tag    <= tag_i;
                s1_index  <= index_i;
                s1_offset <= offset_i;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            enable_o <= 1'b0;
            hit_o    <= 1'b0;
            hitWay_o <= '0;
            tag_o    <= '0;
            index_o  <= '0;
            offset_o <= '0;
        end else if (flushPipeline_i) begin
            enable_o <= 1'b0;
        end else if (!stall_i) begin
            enable_o <= s1_valid;
            hit_o    <= s1_valid && cmp_hit;
            hitWay_o <= (s1_valid && cmp_hit) ? cmp_way : '0;
            tag_o    <= s1_tag;
            index_o  <= s1_index;
            offset_o <= s1_offset;
        end
    end

endmodule

// File: tb/tb_cache_tag_query_assoc.sv
// Directed bench for cache_tag_query_assoc: lookup, fill/replace,
// forwarding, stall/flush, invalidate-all and asynchronous reset.
module tb_cache_tag_query_assoc;

    localparam int OS = 5;
    localparam int IS = 6;
    localparam int TS = 64 - (OS + IS);
    localparam int WB = 2;

    logic          clock_i = 1'b0;
    logic          reset_i;
    logic          fetchEnable_i;
    logic [TS-1:0] tag_i;
    logic [IS-1:0] index_i;
    logic [OS-1:0] offset_i;
    logic          stall_i;
    logic          flushPipeline_i;
    logic          updateEnable_i;
    logic [TS-1:0] newTag_i;
    logic [IS-1:0] newIndex_i;
    logic          invalidateAll_i;
    logic          ready_o;
    logic [WB-1:0] fillWay_o;
    logic          enable_o;
    logic          hit_o;
    logic [WB-1:0] hitWay_o;
    logic [TS-1:0] tag_o;
    logic [IS-1:0] index_o;
    logic [OS-1:0] offset_o;

    int n_checks = 0;
    int n_fail   = 0;

    cache_tag_query_assoc dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .fetchEnable_i(fetchEnable_i), .tag_i(tag_i),
        .index_i(index_i), .offset_i(offset_i),
        .stall_i(stall_i), .flushPipeline_i(flushPipeline_i),
        .updateEnable_i(updateEnable_i), .newTag_i(newTag_i),
        .newIndex_i(newIndex_i), .invalidateAll_i(invalidateAll_i),
        .ready_o(ready_o), .fillWay_o(fillWay_o),
        .enable_o(enable_o), .hit_o(hit_o), .hitWay_o(hitWay_o),
        .tag_o(tag_o), .index_o(index_o), .offset_o(offset_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic idle();
        fetchEnable_i   = 1'b0;
        tag_i           = '0;
        index_i         = '0;
        offset_i        = '0;
        stall_i         = 1'b0;
        flushPipeline_i = 1'b0;
        updateEnable_i  = 1'b0;
        newTag_i        = '0;
        newIndex_i      = '0;
        invalidateAll_i = 1'b0;
    endtask

    task automatic lookup(input logic [TS-1:0] t, input logic [IS-1:0] i,
                          input logic [OS-1:0] o);
        fetchEnable_i = 1'b1;
        tag_i = t;
        index_i = i;
        offset_i = o;
    endtask

    task automatic fill(input logic [TS-1:0] t, input logic [IS-1:0] i);
        updateEnable_i = 1'b1;
        newTag_i = t;
        newIndex_i = i;
    endtask

    task automatic test_reset();
        idle();
        reset_i = 1'b1;
        #12;
        reset_i = 1'b0;
        step();
        n_checks++;
        if (enable_o !== 1'b0) begin n_fail++;
            $display("FAIL reset_enable got %0b want 0", enable_o); end
        n_checks++;
        if ({hit_o, hitWay_o} !== 3'b000) begin n_fail++;
            $display("FAIL reset_hit got %0b/%0d want 0/0", hit_o, hitWay_o); end
        n_checks++;
        if ({tag_o, index_o, offset_o} !== 64'h0) begin n_fail++;
            $display("FAIL reset_addr got %h/%h/%h want 0", tag_o, index_o, offset_o); end
        n_checks++;
        if (ready_o !== 1'b1) begin n_fail++;
            $display("FAIL reset_ready got %0b want 1", ready_o); end
    endtask

    task automatic test_cold_miss();
        lookup(53'h1, 6'd3, 5'd4);
        step();
        idle();
        step();
        n_checks++;
        if ({enable_o, hit_o, hitWay_o} !== 4'b1000) begin n_fail++;
            $display("FAIL cold_miss got en=%0b hit=%0b way=%0d want 1/0/0",
                     enable_o, hit_o, hitWay_o); end
        n_checks++;
        if (tag_o !== 53'h1 || index_o !== 6'd3 || offset_o !== 5'd4) begin
            n_fail++;
            $display("FAIL cold_addr got %h/%0d/%0d want 1/3/4", tag_o, index_o, offset_o); end
        step();
        n_checks++;
        if (enable_o !== 1'b0) begin n_fail++;
            $display("FAIL cold_drop got %0b want 0", enable_o); end
    endtask

    task automatic test_fill_hit();
        logic [TS-1:0] tags [4];
        tags[0] = 53'hA; tags[1] = 53'hB; tags[2] = 53'hC; tags[3] = 53'hD;
        for (int k = 0; k < 4; k++) begin
            fill(tags[k], 6'd3);
            #1;
            n_checks++;
            if (fillWay_o !== WB'(k) || ready_o !== 1'b0) begin n_fail++;
                $display("FAIL fill_way%0d got way=%0d rdy=%0b want %0d/0",
                         k, fillWay_o, ready_o, k); end
            step();
        end
        idle();
        lookup(53'hC, 6'd3, 5'd0);
        step();
        idle();
        step();
        n_checks++;
        if ({enable_o, hit_o, hitWay_o} !== 4'b1110) begin n_fail++;
            $display("FAIL hit_c got en=%0b hit=%0b way=%0d want 1/1/2",
                     enable_o, hit_o, hitWay_o); end
    endtask

    task automatic test_replace();
        fill(53'hE, 6'd3);
        #1;
        n_checks++;
        if (fillWay_o !== 2'd0) begin n_fail++;
            $display("FAIL evict_e got %0d want 0", fillWay_o); end
        step();
        fill(53'hF, 6'd3);
        #1;
        n_checks++;
        if (fillWay_o !== 2'd1) begin n_fail++;
            $display("FAIL evict_f got %0d want 1", fillWay_o); end
        step();
        idle();
        lookup(53'hA, 6'd3, 5'd0);
        step();
        idle();
        step();
        n_checks++;
        if ({enable_o, hit_o} !== 2'b10) begin n_fail++;
            $display("FAIL a_evicted got en=%0b hit=%0b want 1/0", enable_o, hit_o); end
        fill(53'hE, 6'd3);
        #1;
        n_checks++;
        if (fillWay_o !== 2'd0) begin n_fail++;
            $display("FAIL refill_e got %0d want 0", fillWay_o); end
        step();
        fill(53'h10, 6'd3);
        #1;
        n_checks++;
        if (fillWay_o !== 2'd2) begin n_fail++;
            $display("FAIL ptr_kept got %0d want 2", fillWay_o); end
        step();
        idle();
    endtask

    task automatic test_forward();
        lookup(53'h7, 6'd5, 5'd1);
        step();
        idle();
        fill(53'h7, 6'd5);
        #1;
        n_checks++;
        if (fillWay_o !== 2'd0) begin n_fail++;
            $display("FAIL fwd_fillway got %0d want 0", fillWay_o); end
        step();
        idle();
        n_checks++;
        if ({enable_o, hit_o, hitWay_o} !== 4'b1100) begin n_fail++;
            $display("FAIL fwd_hit got en=%0b hit=%0b way=%0d want 1/1/0",
                     enable_o, hit_o, hitWay_o); end
        lookup(53'h7, 6'd5, 5'd0);
        fill(53'h8, 6'd5);
        #1;
        n_checks++;
        if (ready_o !== 1'b0 || fillWay_o !== 2'd1) begin n_fail++;
            $display("FAIL fetch_fill got rdy=%0b way=%0d want 0/1", ready_o, fillWay_o); end
        step();
        idle();
        step();
        n_checks++;
        if (enable_o !== 1'b0) begin n_fail++;
            $display("FAIL no_result got %0b want 0", enable_o); end
        lookup(53'h8, 6'd5, 5'd0);
        step();
        idle();
        step();
        n_checks++;
        if ({enable_o, hit_o, hitWay_o} !== 4'b1101) begin n_fail++;
            $display("FAIL fill8_hit got en=%0b hit=%0b way=%0d want 1/1/1",
                     enable_o, hit_o, hitWay_o); end
    endtask

    task automatic test_back_to_back();
        lookup(53'hE, 6'd3, 5'd1);
        step();
        lookup(53'hD, 6'd3, 5'd2);
        step();
        n_checks++;
        if ({enable_o, hit_o, hitWay_o} !== 4'b1100 || tag_o !== 53'hE) begin
            n_fail++;
            $display("FAIL b2b_first got en=%0b hit=%0b way=%0d tag=%h want 1/1/0/e",
                     enable_o, hit_o, hitWay_o, tag_o); end
        lookup(53'h99, 6'd3, 5'd3);
        stall_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if ({enable_o, hit_o, hitWay_o} !== 4'b1100 || tag_o !== 53'hE ||
                offset_o !== 5'd1 || ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold%0d got en=%0b hit=%0b way=%0d tag=%h rdy=%0b",
                         c, enable_o, hit_o, hitWay_o, tag_o, ready_o); end
        end
        stall_i = 1'b0;
        step();
        idle();
        n_checks++;
        if ({enable_o, hit_o, hitWay_o} !== 4'b1111 || tag_o !== 53'hD) begin
            n_fail++;
            $display("FAIL b2b_second got en=%0b hit=%0b way=%0d tag=%h want 1/1/3/d",
                     enable_o, hit_o, hitWay_o, tag_o); end
        step();
        n_checks++;
        if ({enable_o, hit_o, hitWay_o} !== 4'b1000 || tag_o !== 53'h99) begin
            n_fail++;
            $display("FAIL b2b_third got en=%0b hit=%0b way=%0d tag=%h want 1/0/0/99",
                     enable_o, hit_o, hitWay_o, tag_o); end
        lookup(53'hE, 6'd3, 5'd0);
        step();
        lookup(53'hD, 6'd3, 5'd0);
        step();
        idle();
        stall_i = 1'b1;
        flushPipeline_i = 1'b1;
        step();
        n_checks++;
        if (enable_o !== 1'b0) begin n_fail++;
            $display("FAIL flush_stall got %0b want 0", enable_o); end
        idle();
        step();
        n_checks++;
        if (enable_o !== 1'b0) begin n_fail++;
            $display("FAIL flush_s1 got %0b want 0", enable_o); end
    endtask

    task automatic test_invalidate();
        lookup(53'hE, 6'd3, 5'd0);
        step();
        idle();
        invalidateAll_i = 1'b1;
        fill(53'h55, 6'd9);
        step();
        idle();
        n_checks++;
        if ({enable_o, hit_o} !== 2'b10) begin n_fail++;
            $display("FAIL inv_same_cycle got en=%0b hit=%0b want 1/0", enable_o, hit_o); end
        lookup(53'hD, 6'd3, 5'd0);
        step();
        lookup(53'h55, 6'd9, 5'd0);
        step();
        idle();
        n_checks++;
        if ({enable_o, hit_o} !== 2'b10) begin n_fail++;
            $display("FAIL inv_miss_d got en=%0b hit=%0b want 1/0", enable_o, hit_o); end
        step();
        n_checks++;
        if ({enable_o, hit_o} !== 2'b10) begin n_fail++;
            $display("FAIL inv_fill_dropped got en=%0b hit=%0b want 1/0", enable_o, hit_o); end
        fill(53'h33, 6'd3);
        #1;
        n_checks++;
        if (fillWay_o !== 2'd0) begin n_fail++;
            $display("FAIL inv_fillway got %0d want 0", fillWay_o); end
        step();
        idle();
    endtask

    task automatic test_async_reset();
        fill(53'h21, 6'd7);
        step();
        idle();
        lookup(53'h21, 6'd7, 5'd0);
        step();
        idle();
        step();
        n_checks++;
        if ({enable_o, hit_o} !== 2'b11) begin n_fail++;
            $display("FAIL pre_reset_hit got en=%0b hit=%0b want 1/1", enable_o, hit_o); end
        #2;
        reset_i = 1'b1;
        #1;
        n_checks++;
        if ({enable_o, hit_o} !== 2'b00) begin n_fail++;
            $display("FAIL async_reset got en=%0b hit=%0b want 0/0", enable_o, hit_o); end
        #1;
        reset_i = 1'b0;
        lookup(53'h21, 6'd7, 5'd0);
        step();
        idle();
        step();
        n_checks++;
        if ({enable_o, hit_o} !== 2'b10) begin n_fail++;
            $display("FAIL post_reset_miss got en=%0b hit=%0b want 1/0", enable_o, hit_o); end
        fill(53'h22, 6'd7);
        #1;
        n_checks++;
        if (fillWay_o !== 2'd0) begin n_fail++;
            $display("FAIL post_reset_fillway got %0d want 0", fillWay_o); end
        step();
        idle();
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_fill_hit();
        test_replace();
        test_forward();
        test_back_to_back();
        test_invalidate();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
